// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// master = producer/consumer side, slave = the adder.
interface cla_seq_adder_if #(
  parameter int unsigned W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, a, b, ci, op_sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, op_sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/cla_seq_adder.sv
// W-bit add/subtract processed one N-bit chunk per cycle through a single
// carry-lookahead slice, with valid/ready handshakes on both sides.
module cla_nbit #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N-1:0] g, p;
  logic [N:0]   c;
  logic         acc, prop;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat OR of generate terms gated by the propagate run below it.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;
    c[0] = ci;
    for (int unsigned i = 0; i < N; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int unsigned j = 0; j < i; j++) begin
        acc  = acc | (prop & g[i-1-j]);
        prop = prop & p[i-1-j];
      end
      c[i+1] = acc | (prop & ci);
    end
  end

  assign s  = p ^ c[N-1:0];
  assign co = c[N];
endmodule

module cla_seq_adder #(
  parameter int unsigned W = 64,
  parameter int unsigned N = 16
) (
  input  logic            clk,
  input  logic            rst,
  cla_seq_adder_if.slave  bus
);
  localparam int unsigned K  = W / N;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;

  logic [N-1:0]  cla_a, cla_b, cla_s;
  logic          cla_co;
  logic          last;

  assign cla_a = a_q[cnt_q*N +: N];
  assign cla_b = b_q[cnt_q*N +: N];
  assign last  = (cnt_q == CW'(K - 1));

  cla_nbit #(.N(N)) u_cla (
    .a  (cla_a),
    .b  (cla_b),
    .ci (carry_q),
    .s  (cla_s),
    .co (cla_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && bus.in_valid) begin
      a_d     = bus.a;
      b_d     = bus.op_sub ? ~bus.b : bus.b;
      carry_d = bus.op_sub ? 1'b1 : bus.ci;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[cnt_q*N +: N] = cla_s;
      carry_d             = cla_co;
      cnt_d               = cnt_q + 1'b1;
      if (last) begin
        // a^b'^s at the MSB recovers the carry into the top bit.
        co_d  = cla_co;
        ovf_d = a_q[W-1] ^ b_q[W-1] ^ cla_s[N-1] ^ cla_co;
        cnt_d = '0;
      end
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_q;
    bus.co        = co_q;
    bus.ovf       = ovf_q;
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder (W=64, N=16): directed corner vectors, backpressure,
// mid-operation reset and randomized back-to-back traffic against an arithmetic model.
module tb_cla_seq_adder;
  localparam int unsigned W = 64;
  localparam int unsigned N = 16;
  localparam int unsigned K = W / N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_seq_adder_if #(.W(W)) bus();

  cla_seq_adder #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Returns {ovf, co, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic cin, input logic sub);
    logic [W:0]        u;
    logic signed [W:0] sx, sy, ext;
    logic              c;
    sx = $signed({x[W-1], x});
    sy = $signed({y[W-1], y});
    if (sub) begin
      u   = {1'b0, x} - {1'b0, y};
      c   = (x >= y);
      ext = sx - sy;
    end else begin
      u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      c   = u[W];
      ext = sx + sy + $signed({{W{1'b0}}, cin});
    end
    return {(ext[W] != ext[W-1]), c, u[W-1:0]};
  endfunction

  // Presents one operand bundle (caller is #1 after an edge), then waits for out_valid.
  task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                          input logic isub, input bit rand_rdy, output int lat, output bit to);
    bus.a        = ia;
    bus.b        = ib;
    bus.ci       = ici;
    bus.op_sub   = isub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.ci       = 1'($urandom);
    bus.op_sub   = 1'($urandom);
    lat = 0;
    to  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        to = 1'b0;
        break;
      end
      if (rand_rdy) bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.a         = '1;
    bus.b         = '1;
    bus.ci        = 1'b1;
    bus.op_sub    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b exp 0 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if ({bus.ovf, bus.co, bus.sum} !== '0) begin
      errors++;
      $display("FAIL reset_out ovf=%b co=%b sum=%h exp all zero", bus.ovf, bus.co, bus.sum);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vci[4];
    logic         vsb[4];
    logic [W+1:0] vex[4];
    int           lat;
    bit           to;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vci[0] = 0; vsb[0] = 0;
    vex[0] = {1'b0, 1'b1, 64'h0};
    va[1] = 64'h0000_0000_0000_FFFF; vb[1] = 64'd1; vci[1] = 1; vsb[1] = 0;
    vex[1] = {1'b0, 1'b0, 64'h0000_0000_0001_0001};
    va[2] = 64'd5;                   vb[2] = 64'd7; vci[2] = 1; vsb[2] = 1;
    vex[2] = {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vci[3] = 0; vsb[3] = 0;
    vex[3] = {1'b1, 1'b0, 64'h8000_0000_0000_0000};
    for (int i = 0; i < 4; i++) begin
      issue_op(va[i], vb[i], vci[i], vsb[i], 1'b0, lat, to);
      checks++;
      if (to || lat != int'(K)) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d timeout=%0b exp=%0d", i, lat, to, K);
      end
      checks++;
      if ({bus.ovf, bus.co, bus.sum} !== vex[i]) begin
        errors++;
        $display("FAIL dir%0d_result got ovf=%b co=%b sum=%h exp ovf=%b co=%b sum=%h", i,
                 bus.ovf, bus.co, bus.sum, vex[i][W+1], vex[i][W], vex[i][W-1:0]);
      end
      release_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_return out_valid=%b in_ready=%b exp 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y;
    logic [W+1:0] exp;
    int           lat;
    bit           to;
    x   = 64'h1234_5678_9ABC_DEF0;
    y   = 64'h0FED_CBA9_8765_4321;
    exp = golden(x, y, 1'b1, 1'b0);
    issue_op(x, y, 1'b1, 1'b0, 1'b0, lat, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_timeout out_valid=%b exp 1", bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.ovf, bus.co, bus.sum} !== exp) begin
        errors++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b res=%h exp 1 0 %h", i,
                 bus.out_valid, bus.in_ready, {bus.ovf, bus.co, bus.sum}, exp);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    x   = {$urandom, $urandom};
    y   = {$urandom, $urandom};
    exp = golden(x, y, 1'b0, 1'b1);
    issue_op(x, y, 1'b0, 1'b1, 1'b0, lat, to);
    checks++;
    if (to || {bus.ovf, bus.co, bus.sum} !== exp) begin
      errors++;
      $display("FAIL bp_next timeout=%0b res=%h exp %h", to, {bus.ovf, bus.co, bus.sum}, exp);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int  lat;
    bit  to;
    bit  seen;
    bus.a        = 64'hFFFF_0000_FFFF_0000;
    bus.b        = 64'h0001_0001_0001_0001;
    bus.ci       = 1'b1;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.ovf, bus.co, bus.sum} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs out_valid=%b in_ready=%b ovf=%b co=%b sum=%h exp all zero",
               bus.out_valid, bus.in_ready, bus.ovf, bus.co, bus.sum);
    end
    rst = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_no_valid out_valid seen=1 exp 0");
    end
    issue_op(64'd3, 64'd4, 1'b0, 1'b0, 1'b0, lat, to);
    checks++;
    if (to || lat != int'(K) || bus.sum !== 64'd7) begin
      errors++;
      $display("FAIL midrst_after sum=%h lat=%0d timeout=%0b exp sum=7 lat=%0d", bus.sum, lat, to, K);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    logic         cin, sub;
    logic [W+1:0] exp;
    int           lat, hold;
    bit           to;
    for (int i = 0; i < 1000; i++) begin
      x   = (i % 10 == 0) ? '1 : {$urandom, $urandom};
      y   = (i % 7 == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      cin = 1'($urandom);
      sub = 1'($urandom);
      exp = golden(x, y, cin, sub);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_ready in_ready=%b out_valid=%b exp 1 0", i, bus.in_ready, bus.out_valid);
      end
      issue_op(x, y, cin, sub, 1'b1, lat, to);
      checks++;
      if (to || lat != int'(K) || {bus.ovf, bus.co, bus.sum} !== exp) begin
        errors++;
        $display("FAIL b2b%0d_result res=%h lat=%0d timeout=%0b exp %h lat=%0d", i,
                 {bus.ovf, bus.co, bus.sum}, lat, to, exp, K);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.ovf, bus.co, bus.sum} !== exp) begin
          errors++;
          $display("FAIL b2b%0d_stall out_valid=%b res=%h exp 1 %h", i, bus.out_valid,
                   {bus.ovf, bus.co, bus.sum}, exp);
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder/subtractor that time-shares a single N-bit carry-lookahead adder (`cla_nbit #(N)`) across a W-bit operation. It processes one N-bit chunk per cycle, LSB chunk first, and holds the inter-chunk carry in a register. It sits between an operand producer and a result consumer in the MAC datapath, with valid/ready handshakes on both sides. It trades latency for area when W-bit accumulation/normalisation adds do not need single-cycle results.

## Interface
Parameters:
- `W`, 64: operand/result width; must be a multiple of N.
- `N`, 16: chunk width, i.e. the width of the instantiated `cla_nbit`. K = W/N chunks; K ≥ 1.

Ports:
- `clk`, input, 1: the only clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand bundle valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, W: operand A.
- `b`, input, W: operand B.
- `ci`, input, 1: carry-in for add; ignored for subtract.
- `op_sub`, input, 1: 0 = A+B+ci, 1 = A−B (A + ~B + 1).
- `out_valid`, output, 1: result bundle valid.
- `out_ready`, input, 1: consumer accepts result.
- `sum`, output, W: result.
- `co`, output, 1: carry-out of the MSB chunk (for subtract, 1 = no borrow).
- `ovf`, output, 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - Capture A into a register.
    - Capture B into a register as B (add) or ~B (sub).
    - Set the carry register to `ci` (add) or 1 (sub).
    - Clear chunk counter `cnt` to 0.
    - Go to RUN.
- RUN, one chunk per cycle:
  - Feed chunk `cnt` (bits cnt·N+N−1 : cnt·N) of the captured A and B', plus the carry register, to `cla_nbit`.
  - Write its `s` into the same bit slice of the `sum` register.
  - Load carry ← `co`; `cnt` ← `cnt`+1.
  - When `cnt`==K−1: latch `co`, latch `ovf` = A[W−1] ^ B'[W−1] ^ s[N−1] ^ co (carry-in to MSB XOR carry-out), then go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum`, `co`, `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there; operands are not queued.
- `sum`, `co` and `ovf` are meaningful only while `out_valid`=1. Partial `sum` is visible during RUN but carries no guarantee.
- Captured operands are unaffected by changes on `a`/`b`/`ci`/`op_sub` after acceptance.
- K=1 degenerates to a single RUN cycle; this must work.

## Timing
- Reset values, with `rst` sampled high at an edge:
  - state=IDLE, `cnt`=0, carry=0.
  - `sum`=0, `co`=0, `ovf`=0, `out_valid`=0.
  - `in_ready` is forced to 0 while `rst` is high and is 1 in the first cycle after `rst` is low.
- Latency: with acceptance at edge T, `out_valid` rises after edge T+K.
- Minimum issue interval is K+2 cycles (accept, K RUN, DONE handshake edge); `in_ready` is high the cycle after the DONE→IDLE edge.
- Backpressure: `out_valid` and the result are held indefinitely while `out_ready`=0. `out_ready` outside DONE has no effect.
- Reset in RUN or DONE aborts the operation in the same edge: outputs return to reset values, and no `out_valid` is produced for the aborted operation.
- `out_valid` and `in_ready` are never high in the same cycle.

## Test plan
All scenarios use W=64, N=16 (K=4).
- Full carry ripple: add `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=1, `ci`=0 → `sum`=0, `co`=1, `ovf`=0. `out_valid` rises 4 cycles after the accept edge.
- Chunk-boundary carry: add `a`=0x0000_0000_0000_FFFF, `b`=1, `ci`=1 → `sum`=0x0000_0000_0001_0001, `co`=0, `ovf`=0.
- Subtract with borrow: `op_sub`=1, `a`=5, `b`=7, `ci`=1 (ignored) → `sum`=0xFFFF_FFFF_FFFF_FFFE, `co`=0, `ovf`=0.
- Signed overflow: add `a`=0x7FFF_FFFF_FFFF_FFFF, `b`=1, `ci`=0 → `sum`=0x8000_0000_0000_0000, `co`=0, `ovf`=1.
- Backpressure and ignored input:
  - Hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid` and `a`/`b`.
  - Required: result and `out_valid` stay stable, `in_ready`=0, no new operand is captured.
  - After `out_ready`=1, the next operation completes correctly.
- Reset mid-RUN: assert `rst` for 1 cycle at the 2nd RUN cycle.
  - Required: `out_valid` never asserts for that operation, and all outputs are 0.
  - A following add 3+4 returns `sum`=7 after 4 cycles.
  - Then run 1000 random back-to-back ops, both add and sub with random `out_ready`, checked against a golden model.
